// File: rtl/pc_fetch_ctrl.sv
// PC sequencing and instruction-fetch handshake controller.
// Picks the next PC with priority TRAP > branch > stall hold > PC+4, and raises a sticky fetch error on timeout or a misaligned target.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned MAX_WAIT     = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] PC_CUR,
  output logic        PC_EN,
  output logic [31:0] PC_IN,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  output logic        INSTR_VALID,
  input  logic        STALL,
  input  logic        BR_TAKEN,
  input  logic [31:0] BR_TARGET,
  input  logic        TRAP,
  input  logic [31:0] TRAP_VEC,
  output logic        FETCH_ERR
);

  localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HOLD, S_ERR} state_t;

  state_t           state_q, state_d;
  logic             pend_vld_q, pend_vld_d;
  logic             pend_trap_q, pend_trap_d;
  logic [31:0]      pend_tgt_q, pend_tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic        pc_en, req, valid;
  logic [31:0] pc_in;
  logic        live_vld, live_bad;
  logic [31:0] live_tgt, pc_plus4;

  always_comb begin
    state_d     = state_q;
    pend_vld_d  = pend_vld_q;
    pend_trap_d = pend_trap_q;
    pend_tgt_d  = pend_tgt_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    pc_en       = 1'b0;
    pc_in       = 32'h0;
    req         = 1'b0;
    valid       = 1'b0;

    // A same-cycle TRAP always shadows the branch, including its alignment check.
    live_vld = TRAP | BR_TAKEN;
    live_tgt = TRAP ? TRAP_VEC : BR_TARGET;
    live_bad = live_vld && (live_tgt[1:0] != 2'b00);
    pc_plus4 = PC_CUR + 32'd4;

    case (state_q)
      S_BOOT: begin
        pc_en   = 1'b1;
        pc_in   = RESET_VECTOR;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        req = 1'b1;
        if (live_bad) begin
          err_d      = 1'b1;
          pend_vld_d = 1'b0;
          state_d    = S_ERR;
        end else if (!IMEM_ACK) begin
          // A later branch must not displace a trap already waiting for the ACK.
          if (TRAP || (BR_TAKEN && !(pend_vld_q && pend_trap_q))) begin
            pend_vld_d  = 1'b1;
            pend_trap_d = TRAP;
            pend_tgt_d  = live_tgt;
          end
          if (cnt_q == CNT_LAST) begin
            err_d      = 1'b1;
            pend_vld_d = 1'b0;
            state_d    = S_ERR;
          end
        end else if (live_vld || pend_vld_q) begin
          pc_en      = 1'b1;
          pend_vld_d = 1'b0;
          if (TRAP)                           pc_in = TRAP_VEC;
          else if (pend_vld_q && pend_trap_q) pc_in = pend_tgt_q;
          else if (BR_TAKEN)                  pc_in = BR_TARGET;
          else                                pc_in = pend_tgt_q;
        end else if (!STALL) begin
          valid = 1'b1;
          pc_en = 1'b1;
          pc_in = pc_plus4;
        end else begin
          valid   = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (live_bad) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else if (live_vld) begin
          pc_en   = 1'b1;
          pc_in   = live_tgt;
          state_d = S_FETCH;
        end else if (!STALL) begin
          pc_en   = 1'b1;
          pc_in   = pc_plus4;
          state_d = S_FETCH;
        end
      end
      S_ERR: begin
        if (TRAP && (TRAP_VEC[1:0] == 2'b00)) begin
          pc_en   = 1'b1;
          pc_in   = TRAP_VEC;
          err_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_BOOT;
    endcase

    if (pc_en || (state_q == S_FETCH && IMEM_ACK) || state_d == S_ERR)
      cnt_d = '0;
    else if (state_q == S_FETCH)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_BOOT;
      pend_vld_q  <= 1'b0;
      pend_trap_q <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_vld_q  <= pend_vld_d;
      pend_trap_q <= pend_trap_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  // Target payload is only meaningful while pend_vld_q is set.
  always_ff @(posedge CLK) begin
    pend_tgt_q <= pend_tgt_d;
  end

  assign PC_EN       = pc_en & ~RST;
  assign PC_IN       = RST ? 32'h0 : pc_in;
  assign IMEM_REQ    = req & ~RST;
  assign INSTR_VALID = valid & ~RST;
  assign IMEM_ADDR   = PC_CUR;
  assign FETCH_ERR   = err_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a behavioural PC register closing the PC_IN -> PC_CUR loop.
module tb_pc_fetch_ctrl;

  localparam int unsigned MAX_WAIT = 15;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] PC_CUR;
  logic        PC_EN;
  logic [31:0] PC_IN;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_ACK = 1'b0;
  logic        INSTR_VALID;
  logic        STALL = 1'b0;
  logic        BR_TAKEN = 1'b0;
  logic [31:0] BR_TARGET = 32'h0;
  logic        TRAP = 1'b0;
  logic [31:0] TRAP_VEC = 32'h0;
  logic        FETCH_ERR;

  int checks = 0;
  int failures = 0;

  pc_fetch_ctrl #(.RESET_VECTOR(32'h0000_0000), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .RST(RST), .PC_CUR(PC_CUR), .PC_EN(PC_EN), .PC_IN(PC_IN),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK),
    .INSTR_VALID(INSTR_VALID), .STALL(STALL), .BR_TAKEN(BR_TAKEN),
    .BR_TARGET(BR_TARGET), .TRAP(TRAP), .TRAP_VEC(TRAP_VEC), .FETCH_ERR(FETCH_ERR)
  );

  always #5 CLK = ~CLK;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)        PC_CUR <= 32'h0;
    else if (PC_EN) PC_CUR <= PC_IN;
  end

  typedef struct {
    logic        rst, ack, stall, br;
    logic [31:0] br_tgt;
    logic        trap;
    logic [31:0] trap_vec;
    logic        e_en;
    logic [31:0] e_in;
    logic        e_req, e_vld, e_err;
    logic [31:0] e_cur;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic ack, logic stall, logic br, logic [31:0] brt,
                              logic trap, logic [31:0] tv, logic en, logic [31:0] pin,
                              logic rq, logic vl, logic er, logic [31:0] cur);
    vec_t v;
    v.rst = rst; v.ack = ack; v.stall = stall; v.br = br; v.br_tgt = brt;
    v.trap = trap; v.trap_vec = tv; v.e_en = en; v.e_in = pin;
    v.e_req = rq; v.e_vld = vl; v.e_err = er; v.e_cur = cur;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then compare before the rising edge.
  task automatic step(input string nm, input vec_t v);
    @(negedge CLK);
    RST = v.rst; IMEM_ACK = v.ack; STALL = v.stall;
    BR_TAKEN = v.br; BR_TARGET = v.br_tgt; TRAP = v.trap; TRAP_VEC = v.trap_vec;
    #1;
    chk({nm, ".pc_en"},     {31'h0, PC_EN},       {31'h0, v.e_en});
    chk({nm, ".pc_in"},     PC_IN,                v.e_in);
    chk({nm, ".imem_req"},  {31'h0, IMEM_REQ},    {31'h0, v.e_req});
    chk({nm, ".valid"},     {31'h0, INSTR_VALID}, {31'h0, v.e_vld});
    chk({nm, ".fetch_err"}, {31'h0, FETCH_ERR},   {31'h0, v.e_err});
    chk({nm, ".pc_cur"},    PC_CUR,               v.e_cur);
    chk({nm, ".imem_addr"}, IMEM_ADDR,            v.e_cur);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //              rst ack stl br  br_tgt         trp trap_vec      en  pc_in          rq  vl  er  pc_cur
    tbl.push_back(mk(1, 1,  0,  1,  32'hDEADBEEC, 0,  32'h0,        0,  32'h0,         0,  0,  0,  32'h0));
    tbl.push_back(mk(1, 1,  0,  1,  32'hDEADBEEC, 0,  32'h0,        0,  32'h0,         0,  0,  0,  32'h0));
    tbl.push_back(mk(0, 1,  0,  0,  32'h0,        0,  32'h0,        1,  32'h0,         0,  0,  0,  32'h0));
    tbl.push_back(mk(0, 1,  0,  0,  32'h0,        0,  32'h0,        1,  32'h4,         1,  1,  0,  32'h0));
    tbl.push_back(mk(0, 1,  0,  0,  32'h0,        0,  32'h0,        1,  32'h8,         1,  1,  0,  32'h4));
    tbl.push_back(mk(0, 1,  0,  0,  32'h0,        0,  32'h0,        1,  32'hC,         1,  1,  0,  32'h8));
    tbl.push_back(mk(0, 1,  0,  0,  32'h0,        0,  32'h0,        1,  32'h10,        1,  1,  0,  32'hC));
    tbl.push_back(mk(0, 0,  0,  1,  32'h100,      0,  32'h0,        0,  32'h0,         1,  0,  0,  32'h10));
    tbl.push_back(mk(0, 0,  0,  0,  32'h0,        0,  32'h0,        0,  32'h0,         1,  0,  0,  32'h10));
    tbl.push_back(mk(0, 1,  0,  0,  32'h0,        0,  32'h0,        1,  32'h100,       1,  0,  0,  32'h10));
    tbl.push_back(mk(0, 1,  1,  0,  32'h0,        0,  32'h0,        0,  32'h0,         1,  1,  0,  32'h100));
    tbl.push_back(mk(0, 1,  1,  1,  32'h100,      1,  32'h200,      1,  32'h200,       0,  0,  0,  32'h100));
    tbl.push_back(mk(0, 1,  0,  1,  32'h102,      0,  32'h0,        0,  32'h0,         1,  0,  0,  32'h200));
    tbl.push_back(mk(0, 1,  0,  1,  32'h300,      0,  32'h0,        0,  32'h0,         0,  0,  1,  32'h200));
    tbl.push_back(mk(0, 1,  0,  0,  32'h0,        1,  32'h202,      0,  32'h0,         0,  0,  1,  32'h200));
    tbl.push_back(mk(0, 1,  0,  0,  32'h0,        1,  32'h240,      1,  32'h240,       0,  0,  1,  32'h200));
    tbl.push_back(mk(0, 1,  0,  0,  32'h0,        0,  32'h0,        1,  32'h244,       1,  1,  0,  32'h240));
    tbl.push_back(mk(0, 0,  0,  1,  32'h300,      0,  32'h0,        0,  32'h0,         1,  0,  0,  32'h244));
    tbl.push_back(mk(0, 0,  0,  0,  32'h0,        1,  32'h400,      0,  32'h0,         1,  0,  0,  32'h244));
    tbl.push_back(mk(0, 1,  0,  0,  32'h0,        0,  32'h0,        1,  32'h400,       1,  0,  0,  32'h244));
    tbl.push_back(mk(0, 1,  0,  0,  32'h0,        0,  32'h0,        1,  32'h404,       1,  1,  0,  32'h400));

    foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);

    // Fetch timeout: error must not appear before the MAX_WAIT-th missed ACK.
    for (int k = 1; k <= int'(MAX_WAIT); k++)
      step($sformatf("wait%0d", k), mk(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 0, 0, 32'h404));
    step("err_br_ignored", mk(0, 1, 0, 1, 32'h100, 0, 32'h0, 0, 32'h0, 0, 0, 1, 32'h404));
    step("err_trap",       mk(0, 1, 0, 0, 32'h0, 1, 32'h200, 1, 32'h200, 0, 0, 1, 32'h404));
    step("err_recovered",  mk(0, 1, 0, 0, 32'h0, 0, 32'h0, 1, 32'h204, 1, 1, 0, 32'h200));

    // Wrap at the top of the address space across a two-cycle stall.
    step("wrap_redirect",  mk(0, 1, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'hFFFF_FFFC, 1, 0, 0, 32'h204));
    step("wrap_stall",     mk(0, 1, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 1, 0, 32'hFFFF_FFFC));
    step("wrap_hold1",     mk(0, 1, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'hFFFF_FFFC));
    step("wrap_hold2",     mk(0, 1, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'hFFFF_FFFC));
    step("wrap_release",   mk(0, 1, 0, 0, 32'h0, 0, 32'h0, 1, 32'h0, 0, 0, 0, 32'hFFFF_FFFC));
    step("wrap_fetch",     mk(0, 1, 0, 0, 32'h0, 0, 32'h0, 1, 32'h4, 1, 1, 0, 32'h0));

    // Reset while a branch is pending: the branch must not survive reset.
    step("mid_pend",       mk(0, 0, 0, 1, 32'h100, 0, 32'h0, 0, 32'h0, 1, 0, 0, 32'h4));
    step("mid_reset",      mk(1, 1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0));
    step("mid_boot",       mk(0, 1, 0, 0, 32'h0, 0, 32'h0, 1, 32'h0, 0, 0, 0, 32'h0));
    step("mid_fetch",      mk(0, 1, 0, 0, 32'h0, 0, 32'h0, 1, 32'h4, 1, 1, 0, 32'h0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
